// File: rtl/servo_sequencer.sv
// Frame-aligned position scheduler for the SG90 PWM block: queued (pos, dwell) commands held for N frames.
// Optional SERVO_SEQ_LOOP_EN adds a 'loop' input that re-queues every popped command.
module servo_sequencer #(
    parameter int unsigned FRAME_CYCLES = 2000000,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned DWELL_W      = 8,
    parameter logic [1:0]  IDLE_POS     = 2'b11
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_pos,
    input  logic [DWELL_W-1:0]         cmd_dwell,
    input  logic                       flush,
`ifdef SERVO_SEQ_LOOP_EN
    input  logic                       loop,
`endif
    output logic [1:0]                 pos,
    output logic                       frame_tick,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int unsigned CNT_W  = $clog2(FRAME_CYCLES);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam int unsigned ENT_W  = 2 + DWELL_W;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               frame_tick_q, frame_tick_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [1:0]         pos_q, pos_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FCNT_W-1:0]  count_q, count_d;
    logic [ENT_W-1:0]   mem_q [DEPTH];

    logic               loop_en;
    logic               frame_end;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               rewrite;
    logic               wr_en;
    logic [ENT_W-1:0]   wr_data;
    logic [ENT_W-1:0]   head;

`ifdef SERVO_SEQ_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    assign frame_end = (cnt_q == CNT_W'(FRAME_CYCLES - 1));
    assign empty     = (count_q == '0);
    assign full      = (count_q == FCNT_W'(DEPTH));
    assign cmd_ready = !full && !flush && !loop_en;
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem_q[rd_ptr_q];
    // Pop only on a frame boundary when idle or when the current dwell is expiring.
    assign pop       = !flush && frame_end && !empty &&
                       ((state_q == S_IDLE) || (dwell_q == DWELL_W'(1)));
    assign rewrite   = pop && loop_en;
    assign wr_en     = push || rewrite;
    assign wr_data   = push ? {cmd_pos, cmd_dwell} : head;

    always_comb begin
        state_d      = state_q;
        dwell_d      = dwell_q;
        pos_d        = pos_q;
        done_d       = 1'b0;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        cnt_d        = frame_end ? '0 : cnt_q + CNT_W'(1);
        frame_tick_d = (cnt_d == CNT_W'(FRAME_CYCLES - 1));

        if (flush) begin
            state_d  = S_IDLE;
            dwell_d  = '0;
            pos_d    = IDLE_POS;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                pos_d    = head[ENT_W-1 -: 2];
                dwell_d  = (head[DWELL_W-1:0] == '0) ? DWELL_W'(1) : head[DWELL_W-1:0];
                state_d  = S_HOLD;
            end else if ((state_q == S_HOLD) && frame_end) begin
                if (dwell_q == DWELL_W'(1)) begin
                    state_d = S_IDLE;
                    dwell_d = '0;
                    done_d  = 1'b1;
                end else begin
                    dwell_d = dwell_q - DWELL_W'(1);
                end
            end
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            // A loop rewrite balances its own pop, so only external pushes and plain pops move the count.
            if (push && !(pop && !rewrite)) begin
                count_d = count_q + FCNT_W'(1);
            end else if (!push && pop && !rewrite) begin
                count_d = count_q - FCNT_W'(1);
            end
        end

        busy_d = (state_d == S_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            frame_tick_q <= 1'b0;
            dwell_q      <= '0;
            pos_q        <= IDLE_POS;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            frame_tick_q <= frame_tick_d;
            dwell_q      <= dwell_d;
            pos_q        <= pos_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign pos        = pos_q;
    assign frame_tick = frame_tick_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fifo_count = count_q;

endmodule
